// File: rtl/fp_alu_serial_seq_pkg.sv
// fp_alu_pkg: states, flag indices and opcodes shared by the serial FP sequencer
package fp_alu_pkg;
  typedef enum logic [3:0] {
    S_IDLE   = 4'h0,
    S_LOAD_A = 4'h1,
    S_LOAD_B = 4'h2,
    S_EXEC   = 4'h3,
    S_SEND   = 4'h4,
    S_DONE   = 4'h5
  } state_t;
  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;
  localparam int FLAG_TO = 5;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_CMP = 3'd4;
  localparam logic [2:0] OP_NEG = 3'd7;
  localparam logic [7:0] UNARY_MASK_DEF = 8'b1000_0000;
endpackage

// File: rtl/fp_byte_shreg.sv
// fp_byte_shreg: MSB-first byte shift register with parallel load and a wrapping byte counter
module fp_byte_shreg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic             load_i,
  input  logic [7:0]       byte_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o
);
  localparam int NBYTES = WIDTH / 8;
  localparam int CW = $clog2(NBYTES);
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign last_o = cnt_q == CW'(NBYTES - 1);
  assign data_o = data_q;
  always_comb begin
    data_d = load_i ? load_val_i : shift_i ? {data_q[WIDTH-9:0], byte_i} : data_q;
    cnt_d = (clr_i || load_i || (shift_i && last_o)) ? '0 : shift_i ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q <= '0;
    end else begin
      data_q <= data_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/fp_alu_serial_seq.sv
// fp_alu_serial_seq: byte-serial operand collector, core req/ack handshake with timeout,
// and back-pressured byte-serial result streamer
module fp_alu_serial_seq
  import fp_alu_pkg::*;
#(
  parameter int                    WIDTH      = 32,
  parameter int                    OP_W       = 3,
  parameter logic [(2**OP_W)-1:0]  UNARY_MASK = UNARY_MASK_DEF,
  parameter int                    TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  input  logic             start,
  input  logic [OP_W-1:0]  opcode,
  input  logic             abort,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done,
  output logic             busy,
  output logic [3:0]       state_out,
  output logic [5:0]       flags_out,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  output logic [OP_W-1:0]  core_op,
  output logic             core_req,
  input  logic             core_ack,
  input  logic [WIDTH-1:0] core_result,
  input  logic [4:0]       core_flags
);
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic [5:0] flags_q, flags_d;
  logic [TW-1:0] to_q, to_d;
  logic [WIDTH-1:0] res;
  logic kill, go, tmo, a_shift, b_shift, r_shift, r_load, a_last, b_last, r_last;
  // abort outranks every other event, so it masks all register updates below
  assign kill = abort && state_q != S_IDLE;
  assign go = state_q == S_IDLE && start;
  assign tmo = TIMEOUT != 0 && to_q == TW'(TIMEOUT - 1) && !core_ack;
  assign a_shift = state_q == S_LOAD_A && in_valid && !kill;
  assign b_shift = state_q == S_LOAD_B && in_valid && !kill;
  assign r_load = state_q == S_EXEC && (core_ack || tmo) && !kill;
  assign r_shift = state_q == S_SEND && out_ready && !kill;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = start ? S_LOAD_A : S_IDLE;
      S_LOAD_A: if (a_shift && a_last) state_d = UNARY_MASK[op_q] ? S_EXEC : S_LOAD_B;
      S_LOAD_B: if (b_shift && b_last) state_d = S_EXEC;
      S_EXEC:   if (r_load) state_d = S_SEND;
      S_SEND:   if (r_shift && r_last) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
    flags_d = (go || kill) ? '0 : r_load ? (core_ack ? {1'b0, core_flags} : 6'b100000) : flags_q;
    to_d = (state_q == S_EXEC && !core_ack) ? to_q + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q <= '0;
      flags_q <= '0;
      to_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= go ? opcode : op_q;
      flags_q <= flags_d;
      to_q <= to_d;
    end
  end
  fp_byte_shreg #(.WIDTH(WIDTH)) u_a (
    .clk(clk), .rst_n(rst_n), .clr_i(go), .shift_i(a_shift), .load_i(1'b0),
    .byte_i(in_byte), .load_val_i('0), .data_o(core_a), .last_o(a_last)
  );
  fp_byte_shreg #(.WIDTH(WIDTH)) u_b (
    .clk(clk), .rst_n(rst_n), .clr_i(go), .shift_i(b_shift), .load_i(1'b0),
    .byte_i(in_byte), .load_val_i('0), .data_o(core_b), .last_o(b_last)
  );
  fp_byte_shreg #(.WIDTH(WIDTH)) u_r (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0), .shift_i(r_shift), .load_i(r_load),
    .byte_i(8'h00), .load_val_i(core_ack ? core_result : '0), .data_o(res), .last_o(r_last)
  );
  assign out_byte = res[WIDTH-1:WIDTH-8];
  assign out_valid = state_q == S_SEND;
  assign done = state_q == S_DONE;
  assign busy = state_q != S_IDLE;
  assign state_out = state_q;
  assign flags_out = flags_q;
  assign core_op = op_q;
  assign core_req = state_q == S_EXEC;
endmodule

// File: tb/tb_fp_alu_serial_seq.sv
// tb_fp_alu_serial_seq: randomized transactions against a transaction-level model,
// plus directed 16-bit, back-pressure, timeout, abort and reset scenarios
module tb_fp_alu_serial_seq;
  import fp_alu_pkg::*;
  localparam int NB = 4;
  localparam int TO = 10;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic [7:0] in_byte = 0, out_byte;
  logic in_valid = 0, start = 0, abort = 0, out_ready = 1;
  logic [2:0] opcode = 0, core_op;
  logic out_valid, done, busy, core_req, core_ack;
  logic [3:0] state_out;
  logic [5:0] flags_out;
  logic [31:0] core_a, core_b, core_result = 0;
  logic [4:0] core_flags = 0;
  fp_alu_serial_seq #(.WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid), .start(start),
    .opcode(opcode), .abort(abort), .out_byte(out_byte), .out_valid(out_valid),
    .out_ready(out_ready), .done(done), .busy(busy), .state_out(state_out),
    .flags_out(flags_out), .core_a(core_a), .core_b(core_b), .core_op(core_op),
    .core_req(core_req), .core_ack(core_ack), .core_result(core_result), .core_flags(core_flags)
  );

  logic [7:0] in_byte16 = 0, out_byte16;
  logic in_valid16 = 0, start16 = 0, abort16 = 0, out_ready16 = 1;
  logic [2:0] opcode16 = 0, core_op16;
  logic out_valid16, done16, busy16, core_req16, core_ack16;
  logic [3:0] state_out16;
  logic [5:0] flags_out16;
  logic [15:0] core_a16, core_b16;
  assign core_ack16 = core_req16;
  fp_alu_serial_seq #(.WIDTH(16), .TIMEOUT(0)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte16), .in_valid(in_valid16), .start(start16),
    .opcode(opcode16), .abort(abort16), .out_byte(out_byte16), .out_valid(out_valid16),
    .out_ready(out_ready16), .done(done16), .busy(busy16), .state_out(state_out16),
    .flags_out(flags_out16), .core_a(core_a16), .core_b(core_b16), .core_op(core_op16),
    .core_req(core_req16), .core_ack(core_ack16), .core_result(16'h4000), .core_flags(5'b00001)
  );

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // stub core: acks on EXEC cycle number ack_lat (0-based); unreachable values never ack
  int exec_cyc = 0, ack_lat = 99;
  always @(posedge clk) exec_cyc <= core_req ? exec_cyc + 1 : 0;
  assign core_ack = core_req && exec_cyc == ack_lat;

  // transaction model
  logic [31:0] exp_a, exp_b, exp_res, last_b = 0, cap_a, cap_b;
  logic [2:0] exp_op;
  logic [5:0] exp_flags;
  logic [7:0] got_bytes [NB];
  bit unary, active = 0, prev_req = 0;
  logic [3:0] prev_state = 0;
  int exp_req, idx = 0, req_cnt = 0, valid_cycles = 0, stall_cnt = 0, rdy_mode = 2;

  always @(negedge clk) begin
    if (active) begin
      if (core_req && !prev_req) begin
        chk("core_a", core_a, exp_a);
        chk("core_b", core_b, exp_b);
        chk("core_op", core_op, exp_op);
        chk("exec_entry_from", prev_state, unary ? 4'h1 : 4'h2);
        cap_a = core_a;
        cap_b = core_b;
        req_cnt = 0;
      end
      if (core_req) req_cnt++;
      if (!core_req && prev_req) chk("req_cycles", req_cnt, exp_req);
      if (out_valid) begin
        valid_cycles++;
        if (idx >= NB) chk("out_overrun", idx, NB - 1);
        else begin
          chk("out_byte", out_byte, exp_res[31-8*idx -: 8]);
          got_bytes[idx] = out_byte;
          if (out_ready) idx++;
        end
      end
    end
    prev_req = core_req;
    prev_state = state_out;
  end

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) out_ready = ($urandom % 4) != 0;
    else if (rdy_mode == 1 && idx == 2 && stall_cnt < 5) begin
      out_ready = 0;
      stall_cnt++;
    end else out_ready = 1;
  end

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < NB; i++) begin
      while (gaps && $urandom % 3 == 0) begin
        in_valid = 0;
        in_byte = 8'($urandom);
        start = 1'($urandom);
        opcode = 3'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1;
      start = 0;
      in_byte = w[31-8*i -: 8];
      @(posedge clk); #1;
    end
    in_valid = 0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit gaps);
    @(posedge clk); #1;
    start = 1;
    opcode = op;
    @(posedge clk); #1;
    start = 0;
    opcode = 3'($urandom);
    send_word(a, gaps);
    if (op != OP_NEG) begin
      send_word(b, gaps);
      last_b = b;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [4:0] cf, input int lat, input bit gaps);
    bit seen = 0;
    unary = op == OP_NEG;
    exp_a = a;
    exp_b = unary ? last_b : b;
    exp_op = op;
    exp_res = lat < TO ? res : 32'h0;
    exp_flags = lat < TO ? {1'b0, cf} : 6'b100000;
    exp_req = lat < TO ? lat + 1 : TO;
    ack_lat = lat;
    core_result = res;
    core_flags = cf;
    idx = 0;
    valid_cycles = 0;
    stall_cnt = 0;
    active = 1;
    issue(op, a, b, gaps);
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk("done_seen", seen, 1);
    chk("flags_out", flags_out, exp_flags);
    chk("bytes_out", idx, NB);
    @(negedge clk);
    chk("done_width", done, 0);
    chk("idle_after_done", state_out, 0);
    chk("busy_after_done", busy, 0);
    chk("flags_held", flags_out, exp_flags);
    active = 0;
  endtask

  task automatic wait_send(output bit seen);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk("reached_send", seen, 1);
  endtask

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state_out, 0);
    chk("rst_outs", {out_valid, done, busy, core_req, out_byte}, 0);
    chk("rst_flags", flags_out, 0);
    chk("rst_core", {core_a, core_b, core_op}, 0);
    rst_n = 1;

    // 16-bit MUL: two bytes per operand, exact cycle timing
    @(posedge clk); #1;
    start16 = 1;
    opcode16 = OP_MUL;
    @(posedge clk); #1;
    start16 = 0;
    in_valid16 = 1;
    in_byte16 = 8'h3C;
    @(posedge clk); #1;
    in_byte16 = 8'h00;
    @(posedge clk); #1;
    chk("w16_to_load_b", state_out16, 4'h2);
    in_byte16 = 8'h40;
    @(posedge clk); #1;
    in_byte16 = 8'h00;
    @(posedge clk); #1;
    in_valid16 = 0;
    @(negedge clk);
    chk("w16_req", core_req16, 1);
    chk("w16_ops", {core_a16, core_b16}, 32'h3C00_4000);
    @(negedge clk);
    chk("w16_byte0", {out_valid16, out_byte16}, 9'h140);
    @(negedge clk);
    chk("w16_byte1", {out_valid16, out_byte16}, 9'h100);
    @(negedge clk);
    chk("w16_done", done16, 1);
    chk("w16_flags", flags_out16, 6'b000001);

    // ADD 1.0 + 2.0, core acks on its third EXEC cycle
    rdy_mode = 2;
    run_op(OP_ADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5'b0, 2, 0);
    chk("t1_stream", {got_bytes[0], got_bytes[1], got_bytes[2], got_bytes[3]}, 32'h4040_0000);
    chk("t1_operands", {cap_a, cap_b}, 64'h3F80_0000_4000_0000);

    // back-pressure: five stall cycles on byte 2, gapped input
    rdy_mode = 1;
    run_op(OP_SUB, 32'h1234_5678, 32'h9ABC_DEF0, 32'hA1B2_C3D4, 5'b10000, 1, 1);
    chk("t4_valid_cycles", valid_cycles, 9);
    chk("t4_stream", {got_bytes[0], got_bytes[1], got_bytes[2], got_bytes[3]}, 32'hA1B2_C3D4);

    // timeout, then ack on the last allowed cycle
    rdy_mode = 2;
    run_op(OP_DIV, 32'h4000_0000, 32'h0, 32'hDEAD_BEEF, 5'b01000, 99, 0);
    chk("t5_to_flags", flags_out, 6'b100000);
    chk("t5_to_stream", {got_bytes[0], got_bytes[1], got_bytes[2], got_bytes[3]}, 32'h0);
    run_op(OP_CMP, 32'h1, 32'h2, 32'h0000_0001, 5'b00000, TO - 1, 0);
    chk("t5_ack_wins", flags_out[FLAG_TO], 0);

    // abort after two bytes of A
    @(posedge clk); #1;
    start = 1;
    opcode = OP_ADD;
    @(posedge clk); #1;
    start = 0;
    in_valid = 1;
    in_byte = 8'h11;
    @(posedge clk); #1;
    in_byte = 8'h22;
    @(posedge clk); #1;
    in_valid = 0;
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("abort_load", {state_out, busy, core_req, out_valid, done, flags_out}, 0);

    // abort mid-SEND clears flags and suppresses done
    ack_lat = 0;
    core_result = 32'h5555_AAAA;
    core_flags = 5'b00100;
    issue(OP_MUL, 32'h3, 32'h4, 0);
    wait_send(seen);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("abort_send", {state_out, core_req, out_valid, done, flags_out}, 0);
    @(negedge clk);
    chk("abort_no_done", done, 0);

    // start together with abort in IDLE is honoured
    @(posedge clk); #1;
    start = 1;
    abort = 1;
    @(posedge clk); #1;
    start = 0;
    abort = 0;
    chk("start_over_abort", state_out, 4'h1);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;

    // asynchronous reset mid-SEND
    issue(OP_ADD, 32'hCAFE_F00D, 32'h0BAD_BEEF, 0);
    wait_send(seen);
    rst_n = 0;
    #1;
    chk("arst_state", {state_out, out_valid, done, core_req, out_byte}, 0);
    chk("arst_regs", {core_a, core_b, flags_out}, 0);
    #2 rst_n = 1;
    last_b = 0;

    // unary NEG right after reset: B must still be zero
    run_op(OP_NEG, 32'h3F80_0000, 32'hFFFF_FFFF, 32'hBF80_0000, 5'b0, 0, 1);
    chk("t3_core_b_zero", cap_b, 0);

    rdy_mode = 0;
    for (int n = 0; n < 30; n++)
      run_op(3'($urandom), $urandom, $urandom, $urandom, 5'($urandom), $urandom_range(0, 12), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
